seq_calc: RTL and testbench
===========================

# seq_calc

Parametrised, clocked signed-integer calculator for the board calculator datapath. It latches two W-bit two's-complement operands and a 3-bit opcode on a start handshake, then performs the operation: one cycle for ALU ops, iteratively for multiply and divide. It also keeps a running accumulator. The registered result and overflow flag feed the existing hex-display decode and error ('E') indication.

## Interface
- W, default 8: operand/result width in bits, two's complement; legal range 4..16.
- clk  in  1  rising-edge clock; sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted on a rising edge where start=1 and busy=0.
- op  in  3  opcode, sampled at accept.
- a  in  W  operand A (signed), sampled at accept.
- b  in  W  operand B (signed), sampled at accept.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: result/ovf updated this cycle.
- result  out  W  registered result (signed); holds between done pulses.
- ovf  out  1  registered overflow/error flag; holds with result.
- acc  out  W  accumulator value.

## Operation
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 MUL: a*b, shift-add over W iterations.
  - 011 DIV: a/b, restoring divide on magnitudes over W iterations, quotient truncated toward zero, sign fixed after.
  - 100 ACC: acc+a; acc and result both take the sum.
  - 101 CLR: acc=0, result=0, ovf=0.
  - 110 NEG: -a.
  - 111 ABS: |a|.
- Result width rule: result is always the low W bits of the exact result.
- ovf rules:
  - ADD/SUB/ACC: operand signs agree (SUB: a and -b) and result sign differs.
  - MUL: the 2W-bit product is not representable in W bits signed.
  - NEG/ABS: a = -2^(W-1).
  - DIV: b=0 gives result 0, ovf=1. a=-2^(W-1) with b=-1 gives result -2^(W-1), ovf=1.
  - Otherwise ovf=0.
- The ACC opcode wraps acc on overflow; it does not saturate.
- Operands and op are captured at accept. Input changes after accept have no effect.
- FSM:
  - IDLE, on accept with op=MUL/DIV: go to RUN and load the iteration counter with W.
  - IDLE, on accept with any other op: go to DONE.
  - RUN: decrement the counter each cycle. When it reaches 0, write result/ovf and go to DONE.
  - DONE: done=1 for one cycle. Go to IDLE, or accept a new start in the same cycle (busy=0 in DONE).
- start while busy=1 is ignored and not queued.

## Timing
- Reset: the first clk edge with rst_n=0 sets state IDLE, busy=0, done=0, result=0, ovf=0, acc=0. Reset mid-RUN aborts the operation and no done is produced.
- Single-cycle ops, accept at edge k:
  - result, ovf and acc valid after edge k+1.
  - done=1 between edges k+1 and k+2.
- MUL/DIV, accept at edge k:
  - busy=1 from after edge k through edge k+W.
  - result/ovf valid after edge k+W+1.
  - done=1 for the cycle after edge k+W+1.
  - Latency is W+1 edges, fixed, including divide-by-zero.
- result/ovf change only on edges that raise done.
- Back-to-back: a start accepted during the DONE cycle gives done again after the next op's latency. For single-cycle ops, done stays high on consecutive cycles.

## Test plan
- Reset, then ADD a=100, b=50 (W=8) -> result=0x96 (-106), ovf=1, done exactly one cycle, one edge after accept. Then SUB a=-128, b=1 -> result=0x7F, ovf=1.
- MUL a=-7, b=9 -> result=0xC1 (-63), ovf=0, done 9 edges after accept, busy high for 8 cycles. MUL a=16, b=8 -> result=0x80, ovf=1.
- DIV a=-100, b=7 -> result=0xF2 (-14), ovf=0. DIV a=5, b=0 -> result=0, ovf=1. DIV a=-128, b=-1 -> result=0x80, ovf=1. All three with latency 9.
- ACC sequence, from CLR: a=100, then a=27, then a=1 -> acc=100, then 127, then 0x80 with ovf=1. CLR -> acc=0, result=0, ovf=0.
- Start pulsed and operands changed during a MUL busy window -> ignored; the original product is reported and the prior result holds until done.
- rst_n=0 for one edge midway through a DIV -> all outputs 0 the next cycle, no done. A new ADD accepted the following cycle completes normally. NEG a=-128 -> result=0x80, ovf=1.

Source files
------------

// File: rtl/seq_calc.sv
// rtl/seq_calc.sv - signed W-bit calculator: one-cycle ALU ops, iterative multiply/divide, running accumulator
module seq_calc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic [W-1:0] acc
);
    localparam int CW = $clog2(W + 1);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_ACC = 3'b100;
    localparam logic [2:0] OP_CLR = 3'b101;
    localparam logic [2:0] OP_NEG = 3'b110;
    localparam logic [2:0] OP_ABS = 3'b111;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nx;

    logic [2:0]     rop;
    logic [W-1:0]   ra, rb;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] prod, mcand, pfix;
    logic [W-1:0]   mplier, rem, quo, dvs;
    logic [W:0]     rem_sh, rem_df;
    logic           accept, sgn, fin_ovf;
    logic [W-1:0]   sum, dif, accs, nega, qfix, fin_result;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

    // DONE is the finalize cycle: result lands on the edge leaving it, and a new start may be taken there
    always_comb begin
        state_nx = state;
        busy     = (state == S_RUN);
        accept   = start && (state != S_RUN);
        case (state)
            S_RUN: begin
                if (cnt == CW'(1)) state_nx = S_DONE;
            end
            default: begin
                if (accept) state_nx = (op == OP_MUL || op == OP_DIV) ? S_RUN : S_DONE;
                else        state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        sgn        = ra[W-1] ^ rb[W-1];
        sum        = ra + rb;
        dif        = ra - rb;
        accs       = acc + ra;
        nega       = -ra;
        pfix       = sgn ? -prod : prod;
        qfix       = sgn ? -quo : quo;
        rem_sh     = {rem, quo[W-1]};
        rem_df     = rem_sh - {1'b0, dvs};
        fin_result = '0;
        fin_ovf    = 1'b0;
        case (rop)
            OP_ADD: begin
                fin_result = sum;
                fin_ovf    = (ra[W-1] == rb[W-1]) && (sum[W-1] != ra[W-1]);
            end
            OP_SUB: begin
                fin_result = dif;
                fin_ovf    = (ra[W-1] != rb[W-1]) && (dif[W-1] != ra[W-1]);
            end
            OP_MUL: begin
                fin_result = pfix[W-1:0];
                fin_ovf    = (|pfix[2*W-1:W-1]) && !(&pfix[2*W-1:W-1]);
            end
            OP_DIV: begin
                if (rb == '0) begin
                    fin_ovf = 1'b1;
                end else begin
                    fin_result = qfix;
                    fin_ovf    = (ra == MINV) && (rb == '1);
                end
            end
            OP_ACC: begin
                fin_result = accs;
                fin_ovf    = (acc[W-1] == ra[W-1]) && (accs[W-1] != ra[W-1]);
            end
            OP_NEG: begin
                fin_result = nega;
                fin_ovf    = (ra == MINV);
            end
            OP_ABS: begin
                fin_result = ra[W-1] ? nega : ra;
                fin_ovf    = (ra == MINV);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            acc    <= '0;
            rop    <= OP_ADD;
            ra     <= '0;
            rb     <= '0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                result <= fin_result;
                ovf    <= fin_ovf;
                if (rop == OP_ACC)      acc <= accs;
                else if (rop == OP_CLR) acc <= '0;
            end
            // multiply and divide iterate together on magnitudes; the op picks which one is used
            if (state == S_RUN) begin
                cnt <= cnt - CW'(1);
                if (mplier[0]) prod <= prod + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (!rem_df[W]) begin
                    rem <= rem_df[W-1:0];
                    quo <= {quo[W-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[W-1:0];
                    quo <= {quo[W-2:0], 1'b0};
                end
            end
            if (accept) begin
                rop    <= op;
                ra     <= a;
                rb     <= b;
                cnt    <= CW'(W);
                prod   <= '0;
                mcand  <= {{W{1'b0}}, mag(a)};
                mplier <= mag(b);
                rem    <= '0;
                quo    <= mag(a);
                dvs    <= mag(b);
            end
        end
    end
endmodule

// File: tb/tb_seq_calc.sv
// tb/tb_seq_calc.sv - directed and randomized self-checking bench for seq_calc
module tb_seq_calc;
    localparam int W = 8;

    logic         clk, rst_n, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, ovf;
    logic [W-1:0] result, acc;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] m_acc = '0;

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         v;
    } vec_t;

    seq_calc #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .ovf(ovf), .acc(acc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // exact-integer reference: the low W bits are the result, out-of-range is overflow
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [W-1:0] acc_in, output logic [W-1:0] er,
                                  output logic eo, output logic [W-1:0] eacc);
        int sx, sy, sacc, v;
        logic divz;
        sx = int'($signed(x));
        sy = int'($signed(y));
        sacc = int'($signed(acc_in));
        divz = 1'b0;
        v = 0;
        case (o)
            3'd0: v = sx + sy;
            3'd1: v = sx - sy;
            3'd2: v = sx * sy;
            3'd3: if (sy == 0) divz = 1'b1; else v = sx / sy;
            3'd4: v = sacc + sx;
            3'd5: v = 0;
            3'd6: v = -sx;
            default: v = (sx < 0) ? -sx : sx;
        endcase
        er = v[W-1:0];
        eo = divz || (v > (2 ** (W - 1)) - 1) || (v < -(2 ** (W - 1)));
        eacc = (o == 3'd4) ? er : ((o == 3'd5) ? '0 : acc_in);
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int bcnt, output logic done_after);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        lat = -1;
        bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== '0)   begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
        checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (acc !== '0)      begin errors++; $display("FAIL reset_acc got=%h exp=00", acc); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_acc = '0;
    endtask

    task automatic test_directed();
        vec_t tv[11];
        int lat, bc, elat;
        logic da;
        tv[0]  = '{3'd0, 8'd100, 8'd50,  8'h96, 1'b1};
        tv[1]  = '{3'd1, 8'h80,  8'h01,  8'h7F, 1'b1};
        tv[2]  = '{3'd2, 8'hF9,  8'h09,  8'hC1, 1'b0};
        tv[3]  = '{3'd2, 8'h10,  8'h08,  8'h80, 1'b1};
        tv[4]  = '{3'd3, 8'h9C,  8'h07,  8'hF2, 1'b0};
        tv[5]  = '{3'd3, 8'h05,  8'h00,  8'h00, 1'b1};
        tv[6]  = '{3'd3, 8'h80,  8'hFF,  8'h80, 1'b1};
        tv[7]  = '{3'd6, 8'h80,  8'h00,  8'h80, 1'b1};
        tv[8]  = '{3'd7, 8'h80,  8'h00,  8'h80, 1'b1};
        tv[9]  = '{3'd7, 8'hF6,  8'h00,  8'h0A, 1'b0};
        tv[10] = '{3'd1, 8'h00,  8'h80,  8'h80, 1'b1};
        for (int i = 0; i < 11; i++) begin
            elat = (tv[i].o == 3'd2 || tv[i].o == 3'd3) ? W + 1 : 1;
            run_op(tv[i].o, tv[i].x, tv[i].y, lat, bc, da);
            checks++; if (result !== tv[i].r) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, result, tv[i].r); end
            checks++; if (ovf !== tv[i].v)    begin errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, tv[i].v); end
            checks++; if (lat !== elat)       begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
            checks++; if (da !== 1'b0)        begin errors++; $display("FAIL dir%0d_done_width got=%b exp=0", i, da); end
            checks++; if (acc !== m_acc)      begin errors++; $display("FAIL dir%0d_acc got=%h exp=%h", i, acc, m_acc); end
            if (elat != 1) begin
                checks++; if (bc !== W) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, W); end
            end
        end
    endtask

    task automatic test_acc();
        logic [2:0]   so[5] = '{3'd5, 3'd4, 3'd4, 3'd4, 3'd5};
        logic [W-1:0] sx[5] = '{8'd9, 8'd100, 8'd27, 8'd1, 8'd3};
        logic [W-1:0] ea[5] = '{8'h00, 8'd100, 8'd127, 8'h80, 8'h00};
        logic         eo[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat, bc;
        logic da;
        for (int i = 0; i < 5; i++) begin
            run_op(so[i], sx[i], 8'h55, lat, bc, da);
            checks++; if (acc !== ea[i])    begin errors++; $display("FAIL acc%0d_acc got=%h exp=%h", i, acc, ea[i]); end
            checks++; if (result !== ea[i]) begin errors++; $display("FAIL acc%0d_result got=%h exp=%h", i, result, ea[i]); end
            checks++; if (ovf !== eo[i])    begin errors++; $display("FAIL acc%0d_ovf got=%b exp=%b", i, ovf, eo[i]); end
            checks++; if (lat !== 1)        begin errors++; $display("FAIL acc%0d_latency got=%0d exp=1", i, lat); end
        end
        m_acc = '0;
    endtask

    task automatic test_ignore_busy();
        int lat, bc;
        logic da;
        run_op(3'd0, 8'd3, 8'd4, lat, bc, da);
        checks++; if (result !== 8'd7) begin errors++; $display("FAIL ign_prior got=%h exp=07", result); end
        op = 3'd2; a = 8'hF9; b = 8'h09; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd0; a = 8'd1; b = 8'd1;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            checks++; if (result !== 8'd7) begin errors++; $display("FAIL ign_hold%0d got=%h exp=07", n, result); end
            checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ign_status%0d got=%b%b exp=01", n, done, busy); end
        end
        start = 1'b0;
        lat = -1;
        for (int n = 4; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat !== W + 1)    begin errors++; $display("FAIL ign_latency got=%0d exp=%0d", lat, W + 1); end
        checks++; if (result !== 8'hC1) begin errors++; $display("FAIL ign_result got=%h exp=c1", result); end
        checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL ign_ovf got=%b exp=0", ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        int lat, bc;
        logic da;
        run_op(3'd4, 8'd5, 8'd0, lat, bc, da);
        checks++; if (acc !== 8'd5) begin errors++; $display("FAIL rmd_acc_pre got=%h exp=05", acc); end
        op = 3'd3; a = 8'h9C; b = 8'h07; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_acc = '0;
        checks++; if ({busy, done, ovf} !== 3'b000) begin errors++; $display("FAIL rmd_flags got=%b exp=000", {busy, done, ovf}); end
        checks++; if (result !== '0) begin errors++; $display("FAIL rmd_result got=%h exp=00", result); end
        checks++; if (acc !== '0)    begin errors++; $display("FAIL rmd_acc got=%h exp=00", acc); end
        run_op(3'd0, 8'd20, 8'd30, lat, bc, da);
        checks++; if (result !== 8'd50) begin errors++; $display("FAIL rmd_add_result got=%h exp=32", result); end
        checks++; if (lat !== 1)        begin errors++; $display("FAIL rmd_add_latency got=%0d exp=1", lat); end
        checks++; if (da !== 1'b0)      begin errors++; $display("FAIL rmd_add_done_width got=%b exp=0", da); end
    endtask

    task automatic test_back_to_back();
        int lat;
        op = 3'd0; a = 8'd10; b = 8'd20; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hFB; b = 8'd3;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || result !== 8'd30) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/1e", done, result); end
        op = 3'd2; a = 8'd6; b = 8'd7;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || result !== 8'hFE) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/fe", done, result); end
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat !== W + 1)    begin errors++; $display("FAIL b2b_mul_latency got=%0d exp=%0d", lat, W + 1); end
        checks++; if (result !== 8'd42) begin errors++; $display("FAIL b2b_mul_result got=%h exp=2a", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, bc, elat;
        logic da, eo;
        logic [2:0] o;
        logic [W-1:0] x, y, er, eacc;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 7) == 0) x = 8'h80;
            if ($urandom_range(0, 7) == 0) y = (o == 3'd3) ? 8'h00 : 8'hFF;
            model(o, x, y, m_acc, er, eo, eacc);
            elat = (o == 3'd2 || o == 3'd3) ? W + 1 : 1;
            run_op(o, x, y, lat, bc, da);
            m_acc = eacc;
            checks++; if (result !== er)   begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, result, er); end
            checks++; if (ovf !== eo)      begin errors++; $display("FAIL rnd%0d_ovf op=%0d a=%h b=%h got=%b exp=%b", i, o, x, y, ovf, eo); end
            checks++; if (acc !== eacc)    begin errors++; $display("FAIL rnd%0d_acc op=%0d got=%h exp=%h", i, o, acc, eacc); end
            checks++; if (lat !== elat)    begin errors++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, o, lat, elat); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_acc();
        test_ignore_busy();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
